nand_logic_unit: RTL



---
 rtl/nand_logic_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/nand_logic_unit.sv
// Registered WIDTH-bit logic unit with valid/ready handshake and a saturating
// transfer counter; every function is composed from 2-input NAND gates only.

module nand_logic_lane (
  input  logic       a_i,
  input  logic       b_i,
  input  logic [2:0] op_i,
  output logic       y_o
);
  function automatic logic n(input logic x, input logic z);
    return ~(x & z);
  endfunction

  logic na, nb, t, f_and, f_or, f_nor, f_xor, f_xnor, f_buf;

  always_comb begin
    na     = n(a_i, a_i);
    nb     = n(b_i, b_i);
    t      = n(a_i, b_i);
    f_and  = n(t, t);
    f_or   = n(na, nb);
    f_nor  = n(f_or, f_or);
    f_xor  = n(n(a_i, t), n(b_i, t));
    f_xnor = n(f_xor, f_xor);
    f_buf  = n(na, na);
    case (op_i)
      3'd0:    y_o = na;
      3'd1:    y_o = t;
      3'd2:    y_o = f_and;
      3'd3:    y_o = f_or;
      3'd4:    y_o = f_nor;
      3'd5:    y_o = f_xor;
      3'd6:    y_o = f_xnor;
      default: y_o = f_buf;
    endcase
  end
endmodule

module nand_logic_unit #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  input  logic               count_clr,
  output logic [COUNT_W-1:0] xfer_count
);
  logic [WIDTH-1:0]   y_d, y_q;
  logic               vld_d, vld_q;
  logic [COUNT_W-1:0] cnt_d, cnt_q;
  logic               accept, xfer;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    nand_logic_lane u_lane (
      .a_i  (a[i]),
      .b_i  (b[i]),
      .op_i (op),
      .y_o  (y_d[i])
    );
  end

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = vld_q && out_ready;

  always_comb begin
    vld_d = vld_q;
    if (accept)    vld_d = 1'b1;
    else if (xfer) vld_d = 1'b0;
  end

  // Clear wins over a same-cycle transfer; the counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (count_clr)             cnt_d = '0;
    else if (xfer && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (accept) y_q <= y_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign y          = y_q;
  assign out_valid  = vld_q;
  assign xfer_count = cnt_q;
endmodule
